bcd_score_bank: RTL and testbench

- Multi-channel, N-digit BCD up/down score register bank for the Pong scoreboard.
- One channel per player.
- Per-channel increment/decrement pulses, global clear, selectable saturate or wrap at the range limits, and latched win detection with winner index.
- Sits between the game-logic FSM, which issues single-cycle pulses, and the 7-segment/VGA score renderers, which consume packed BCD digits.

---
 rtl/score_pkg.sv | 15 +
 rtl/bcd_updown_chan.sv | 85 ++++++++
 rtl/bcd_score_bank.sv | 81 ++++++++
 tb/tb_bcd_score_bank.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared BCD constants and width helpers for the scoreboard score bank.
package score_pkg;

    localparam int unsigned BCD_DIGIT_W   = 4;
    localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;

    function automatic int unsigned bcd_w(input int unsigned n);
        return BCD_DIGIT_W * n;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_updown_chan.sv
// One score channel: NUM_DIGITS packed BCD digits with ripple carry/borrow up/down counting.
module bcd_updown_chan
    import score_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter bit          WRAP       = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        inc,
    input  logic                        dec,
    input  logic                        en,
    output logic [bcd_w(NUM_DIGITS)-1:0] value,
    output logic [bcd_w(NUM_DIGITS)-1:0] next_value,
    output logic                        at_zero,
    output logic                        at_max
);

    localparam int unsigned VW = bcd_w(NUM_DIGITS);

    logic [VW-1:0] value_q, value_d;
    logic [VW-1:0] inc_val, dec_val;
    logic          zero_c, max_c;

    // Ripple increment/decrement; the all-9s and all-0s cases fall out as natural wrap.
    always_comb begin
        logic carry, borrow;
        logic [3:0] dig;
        inc_val = value_q;
        dec_val = value_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            dig = value_q[d*BCD_DIGIT_W +: BCD_DIGIT_W];
            if (carry) begin
                if (dig == BCD_DIGIT_MAX) begin
                    inc_val[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
                end else begin
                    inc_val[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(dig + 4'd1);
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    dec_val[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_MAX;
                end else begin
                    dec_val[d*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'(dig - 4'd1);
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        zero_c = (value_q == '0);
        max_c  = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (value_q[d*BCD_DIGIT_W +: BCD_DIGIT_W] != BCD_DIGIT_MAX) max_c = 1'b0;
        end
    end

    // clr beats everything; inc&dec together hold; saturation blocks the wrap when WRAP=0.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (en && inc && !dec) begin
            if (!(max_c && !WRAP)) value_d = inc_val;
        end else if (en && dec && !inc) begin
            if (!(zero_c && !WRAP)) value_d = dec_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value      = value_q;
    assign next_value = value_d;
    assign at_zero    = zero_c;
    assign at_max     = max_c;

endmodule

// File: rtl/bcd_score_bank.sv
// Multi-channel BCD score bank with latched win detection and lowest-index winner.
module bcd_score_bank
    import score_pkg::*;
#(
    parameter int unsigned                   NUM_CH      = 2,
    parameter int unsigned                   NUM_DIGITS  = 2,
    parameter bit                            WRAP        = 1'b0,
    parameter logic [bcd_w(NUM_DIGITS)-1:0]  WIN_SCORE   = 'h11,
    parameter bit                            LOCK_ON_WIN = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 clr,
    input  logic [NUM_CH-1:0]                    inc,
    input  logic [NUM_CH-1:0]                    dec,
    output logic [NUM_CH*bcd_w(NUM_DIGITS)-1:0]  scores,
    output logic [NUM_CH-1:0]                    at_zero,
    output logic [NUM_CH-1:0]                    at_max,
    output logic                                 win,
    output logic [idx_w(NUM_CH)-1:0]             winner
);

    localparam int unsigned VW = bcd_w(NUM_DIGITS);
    localparam int unsigned CW = idx_w(NUM_CH);

    logic [VW-1:0]     next_val [NUM_CH];
    logic [NUM_CH-1:0] match_c;
    logic              en_c;
    logic              win_q, win_d;
    logic [CW-1:0]     winner_q, winner_d;

    assign en_c = !(LOCK_ON_WIN && win_q);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        bcd_updown_chan #(
            .NUM_DIGITS (NUM_DIGITS),
            .WRAP       (WRAP)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .clr        (clr),
            .inc        (inc[i]),
            .dec        (dec[i]),
            .en         (en_c),
            .value      (scores[i*VW +: VW]),
            .next_value (next_val[i]),
            .at_zero    (at_zero[i]),
            .at_max     (at_max[i])
        );
        assign match_c[i] = (next_val[i] == WIN_SCORE);
    end

    // Win latches on the edge the matching score lands; lowest matching channel wins.
    always_comb begin
        win_d    = win_q;
        winner_d = winner_q;
        if (clr) begin
            win_d    = 1'b0;
            winner_d = '0;
        end else if (!win_q && (WIN_SCORE != '0) && (match_c != '0)) begin
            win_d = 1'b1;
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (match_c[i]) winner_d = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q    <= 1'b0;
            winner_q <= '0;
        end else begin
            win_q    <= win_d;
            winner_q <= winner_d;
        end
    end

    assign win    = win_q;
    assign winner = winner_q;

endmodule

// File: tb/tb_bcd_score_bank.sv
// Directed bench for bcd_score_bank: default, wrapping and win-disabled configurations.
module tb_bcd_score_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Default configuration: saturate, win at 'h11, lock on win
    logic        clr_a = 1'b0;
    logic [1:0]  inc_a = '0, dec_a = '0;
    logic [15:0] scores_a;
    logic [1:0]  at_zero_a, at_max_a;
    logic        win_a;
    logic [0:0]  winner_a;

    // Wrapping, win disabled
    logic        clr_w = 1'b0;
    logic [1:0]  inc_w = '0, dec_w = '0;
    logic [15:0] scores_w;
    logic [1:0]  at_zero_w, at_max_w;
    logic        win_w;
    logic [0:0]  winner_w;

    // Saturating, win disabled
    logic        clr_n = 1'b0;
    logic [1:0]  inc_n = '0, dec_n = '0;
    logic [15:0] scores_n;
    logic [1:0]  at_zero_n, at_max_n;
    logic        win_n;
    logic [0:0]  winner_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_score_bank #(.NUM_CH(2), .NUM_DIGITS(2), .WRAP(1'b0), .WIN_SCORE(8'h11), .LOCK_ON_WIN(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .clr(clr_a), .inc(inc_a), .dec(dec_a),
        .scores(scores_a), .at_zero(at_zero_a), .at_max(at_max_a), .win(win_a), .winner(winner_a));

    bcd_score_bank #(.NUM_CH(2), .NUM_DIGITS(2), .WRAP(1'b1), .WIN_SCORE(8'h00), .LOCK_ON_WIN(1'b1)) u_dut_w (
        .clk(clk), .reset(reset), .clr(clr_w), .inc(inc_w), .dec(dec_w),
        .scores(scores_w), .at_zero(at_zero_w), .at_max(at_max_w), .win(win_w), .winner(winner_w));

    bcd_score_bank #(.NUM_CH(2), .NUM_DIGITS(2), .WRAP(1'b0), .WIN_SCORE(8'h00), .LOCK_ON_WIN(1'b1)) u_dut_n (
        .clk(clk), .reset(reset), .clr(clr_n), .inc(inc_n), .dec(dec_n),
        .scores(scores_n), .at_zero(at_zero_n), .at_max(at_max_n), .win(win_n), .winner(winner_n));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #23;
        reset = 1'b0;
        tick(1);
        check_val("rst_scores", 32'(scores_a), 32'h0000);
        check_val("rst_at_zero", 32'(at_zero_a), 32'h3);
        check_val("rst_at_max", 32'(at_max_a), 32'h0);
        check_val("rst_win", 32'(win_a), 32'h0);
        check_val("rst_winner", 32'(winner_a), 32'h0);

        // Ten increments on ch0 carry into the tens digit
        inc_a = 2'b01;
        tick(10);
        inc_a = 2'b00;
        check_val("inc10_scores", 32'(scores_a), 32'h0010);
        check_val("inc10_at_zero", 32'(at_zero_a), 32'h2);

        // Saturating decrement at zero
        dec_a = 2'b10;
        tick(1);
        dec_a = 2'b00;
        check_val("dec_sat_zero", 32'(scores_a), 32'h0010);

        // Bring ch1 to 'h10, then a simultaneous inc hits the win on both; lowest index wins
        inc_a = 2'b10;
        tick(10);
        check_val("ch1_at_10", 32'(scores_a), 32'h1010);
        check_val("pre_win", 32'(win_a), 32'h0);
        inc_a = 2'b11;
        tick(1);
        check_val("dual_win_scores", 32'(scores_a), 32'h1111);
        check_val("dual_win", 32'(win_a), 32'h1);
        check_val("dual_winner", 32'(winner_a), 32'h0);
        inc_a = 2'b10;
        tick(1);
        inc_a = 2'b00;
        check_val("locked_scores", 32'(scores_a), 32'h1111);

        // Clear, then ch1 alone reaches the target
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check_val("clr_scores", 32'(scores_a), 32'h0000);
        check_val("clr_win", 32'(win_a), 32'h0);
        check_val("clr_winner", 32'(winner_a), 32'h0);
        inc_a = 2'b10;
        tick(10);
        check_val("ch1_10_nowin", 32'(win_a), 32'h0);
        tick(1);
        inc_a = 2'b00;
        check_val("ch1_win_scores", 32'(scores_a), 32'h1100);
        check_val("ch1_win", 32'(win_a), 32'h1);
        check_val("ch1_winner", 32'(winner_a), 32'h1);

        // Async reset mid-burst, observed before the next clock edge
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        inc_a = 2'b01;
        tick(7);
        check_val("burst_07", 32'(scores_a), 32'h0007);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_scores", 32'(scores_a), 32'h0000);
        check_val("async_rst_win", 32'(win_a), 32'h0);
        check_val("async_rst_at_zero", 32'(at_zero_a), 32'h3);
        inc_a = 2'b00;
        tick(1);
        reset = 1'b0;
        tick(1);
        check_val("post_rst_scores", 32'(scores_a), 32'h0000);

        // Wrap configuration: 00 -> 99 -> 00
        dec_w = 2'b10;
        tick(1);
        dec_w = 2'b00;
        check_val("wrap_dec", 32'(scores_w), 32'h9900);
        check_val("wrap_at_max", 32'(at_max_w), 32'h2);
        inc_w = 2'b10;
        tick(1);
        inc_w = 2'b00;
        check_val("wrap_inc", 32'(scores_w), 32'h0000);
        check_val("wrap_win_off", 32'(win_w), 32'h0);

        // Saturation at 99, borrow, and inc&dec hold
        inc_n = 2'b01;
        tick(99);
        check_val("sat_99", 32'(scores_n), 32'h0099);
        check_val("sat_at_max", 32'(at_max_n), 32'h1);
        tick(1);
        inc_n = 2'b00;
        check_val("sat_hold", 32'(scores_n), 32'h0099);
        check_val("sat_no_win", 32'(win_n), 32'h0);
        dec_n = 2'b01;
        tick(1);
        dec_n = 2'b00;
        check_val("dec_from_99", 32'(scores_n), 32'h0098);
        inc_n = 2'b10;
        tick(5);
        inc_n = 2'b00;
        check_val("ch1_05", 32'(scores_n), 32'h0598);
        inc_n = 2'b10;
        dec_n = 2'b10;
        tick(1);
        inc_n = 2'b00;
        dec_n = 2'b00;
        check_val("incdec_hold", 32'(scores_n), 32'h0598);
        inc_n = 2'b10;
        tick(5);
        inc_n = 2'b00;
        dec_n = 2'b10;
        tick(1);
        dec_n = 2'b00;
        check_val("borrow_10_09", 32'(scores_n), 32'h0998);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
